// File: rtl/tri_dispatcher_pkg.sv
// Shared state encodings and the round-robin channel search for tri_dispatcher.
package tri_disp_pkg;
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] FETCH    = 2'd1;
   localparam logic [1:0] DISPATCH = 2'd2;

   localparam logic [1:0] CH_FREE    = 2'd0;
   localparam logic [1:0] CH_BUSY    = 2'd1;
   localparam logic [1:0] CH_RELEASE = 2'd2;

   localparam int MAX_CH = 8;

   // Returns {found, index} of the first set bit of free at or after ptr, wrapping at n.
   function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] free,
                                          input logic [2:0] ptr, input int n);
      logic [3:0] pick;
      logic [2:0] i3;
      pick = '0;
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         if (k < n) begin
            i3 = 3'((int'(ptr) + k) % n);
            if (free[i3]) pick = {1'b1, i3};
         end
      end
      return pick;
   endfunction
endpackage

// File: rtl/tri_dispatcher_ch_handshake.sv
// One rasteriser channel: 4-phase req/ack FSM plus the triangle data it holds.
module ch_handshake
   import tri_disp_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                ack,
   input  logic [4*DATA_W-1:0] load_data,
   output logic                req,
   output logic                free,
   output logic [4*DATA_W-1:0] data
);
   logic [1:0] state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CH_FREE;
         data  <= '0;
      end else begin
         case (state)
            CH_FREE:    if (start) begin
                           state <= CH_BUSY;
                           data  <= load_data;
                        end
            CH_BUSY:    if (ack) state <= CH_RELEASE;
            CH_RELEASE: if (!ack) state <= CH_FREE;
            default:    state <= CH_FREE;
         endcase
      end
   end

   assign req = (state == CH_BUSY);
   // A stale ack left high keeps the channel out of the free pool.
   assign free = (state == CH_FREE) && !ack;
endmodule

// File: rtl/tri_dispatcher.sv
// Walks the triangle ROMs and hands each triangle to a free rasteriser channel.
module tri_dispatcher
   import tri_disp_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int NUM_TRI = 16,
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     key_n,
   input  logic                     mode_auto,
   output logic [ADDR_W-1:0]        address,
   input  logic [DATA_W-1:0]        point_a,
   input  logic [DATA_W-1:0]        point_b,
   input  logic [DATA_W-1:0]        point_c,
   input  logic [DATA_W-1:0]        color,
   output logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH*DATA_W-1:0] ch_a,
   output logic [NUM_CH*DATA_W-1:0] ch_b,
   output logic [NUM_CH*DATA_W-1:0] ch_c,
   output logic [NUM_CH*DATA_W-1:0] ch_color,
   output logic                     busy,
   output logic                     frame_done
);
   logic                             key_s1, key_s2, key_d, trig;
   logic [1:0]                       state;
   logic                             mode_r;
   logic [2:0]                       rr_ptr;
   logic [NUM_CH-1:0]                chan_free, start;
   logic [MAX_CH-1:0]                free_pad;
   logic [3:0]                       pick;
   logic                             dispatch, last;
   logic [4*DATA_W-1:0]              rom_word;
   logic [NUM_CH-1:0][4*DATA_W-1:0]  chan_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
         key_d  <= 1'b1;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
         key_d  <= key_s2;
      end
   end

   assign trig = key_d & ~key_s2;

   always_comb begin
      free_pad = '0;
      free_pad[NUM_CH-1:0] = chan_free;
   end

   assign pick     = rr_pick(free_pad, rr_ptr, NUM_CH);
   assign dispatch = (state == DISPATCH) && pick[3];
   assign last     = (address == ADDR_W'(NUM_TRI - 1));
   assign rom_word = {point_a, point_b, point_c, color};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mode_r     <= 1'b0;
         rr_ptr     <= '0;
         address    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE:     if (trig) begin
                         mode_r <= mode_auto;
                         state  <= FETCH;
                      end
            FETCH:    state <= DISPATCH;
            DISPATCH: if (pick[3]) begin
                         rr_ptr     <= 3'((int'(pick[2:0]) + 1) % NUM_CH);
                         address    <= last ? '0 : address + ADDR_W'(1);
                         frame_done <= last;
                         state      <= (mode_r && !last) ? FETCH : IDLE;
                      end
            default:  state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE) || !(&chan_free);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign start[i] = dispatch && (pick[2:0] == 3'(i));

      ch_handshake #(.DATA_W(DATA_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .start     (start[i]),
         .ack       (ch_ack[i]),
         .load_data (rom_word),
         .req       (ch_req[i]),
         .free      (chan_free[i]),
         .data      (chan_data[i])
      );

      assign ch_a    [i*DATA_W +: DATA_W] = chan_data[i][4*DATA_W-1 -: DATA_W];
      assign ch_b    [i*DATA_W +: DATA_W] = chan_data[i][3*DATA_W-1 -: DATA_W];
      assign ch_c    [i*DATA_W +: DATA_W] = chan_data[i][2*DATA_W-1 -: DATA_W];
      assign ch_color[i*DATA_W +: DATA_W] = chan_data[i][DATA_W-1:0];
   end
endmodule
